nmr_bstrm_pls_meas: RTL and testbench

Receive-side companion to the NMR pulse bitstream datapath. The generator emits initial delay, pulse, then post-pulse delay on a one-bit stream. This block arms on START, samples a one-bit input stream, and measures in CLK cycles the initial low time, the high (pulse) time and the post-pulse low time. It sits on the loopback/monitor path, so software can check generated pulse timing against the programmed idly/pls/edly values.

---
 rtl/nmr_bstrm_pls_meas_if.sv | 27 ++
 rtl/nmr_bstrm_pls_meas.sv | 171 +++++++++++++++++
 tb/tb_nmr_bstrm_pls_meas.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nmr_bstrm_pls_meas_if.sv
// Bus bundle for the pulse-timing monitor: arm/stream/timeout in, status and measurements out.
interface nmr_bstrm_pls_meas_if #(
  parameter int unsigned IDLY_WIDTH = 32,
  parameter int unsigned PLS_WIDTH  = 32,
  parameter int unsigned EDLY_WIDTH = 32,
  parameter int unsigned TMO_WIDTH  = 32
);
  logic                  START;
  logic                  IN;
  logic [TMO_WIDTH-1:0]  tmo;
  logic                  BUSY;
  logic                  DONE;
  logic [IDLY_WIDTH-1:0] idly_m;
  logic [PLS_WIDTH-1:0]  pls_m;
  logic [EDLY_WIDTH-1:0] edly_m;
  logic [2:0]            err;

  modport master (
    output START, IN, tmo,
    input  BUSY, DONE, idly_m, pls_m, edly_m, err
  );

  modport slave (
    input  START, IN, tmo,
    output BUSY, DONE, idly_m, pls_m, edly_m, err
  );
endinterface

// File: rtl/nmr_bstrm_pls_meas.sv
// Measures initial-low, pulse-high and post-pulse-low durations (in CLK cycles) of a
// one-bit stream after an arm request, with optional per-phase timeout.
module nmr_bstrm_pls_meas #(
  parameter int unsigned IDLY_WIDTH = 32,
  parameter int unsigned PLS_WIDTH  = 32,
  parameter int unsigned EDLY_WIDTH = 32,
  parameter int unsigned TMO_WIDTH  = 32
) (
  input logic CLK,
  input logic RST,
  nmr_bstrm_pls_meas_if.slave bus
);

  localparam int unsigned MAX_A = (IDLY_WIDTH > PLS_WIDTH) ? IDLY_WIDTH : PLS_WIDTH;
  localparam int unsigned MAX_B = (EDLY_WIDTH > TMO_WIDTH) ? EDLY_WIDTH : TMO_WIDTH;
  localparam int unsigned CMP_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_WAIT_HI,
    S_HIGH,
    S_LOW_POST,
    S_FIN
  } state_t;

  state_t                state;
  logic                  align;
  logic                  in_s1;
  logic                  in_s2;
  logic [TMO_WIDTH-1:0]  tmo_q;
  logic [IDLY_WIDTH-1:0] idly_cnt;
  logic [PLS_WIDTH-1:0]  pls_cnt;
  logic [EDLY_WIDTH-1:0] edly_cnt;
  logic [2:0]            err_q;

  logic [IDLY_WIDTH-1:0] idly_inc;
  logic [PLS_WIDTH-1:0]  pls_inc;
  logic [EDLY_WIDTH-1:0] edly_inc;
  logic                  tmo_on;
  logic                  tmo_one;
  logic                  idly_hit;
  logic                  pls_hit;
  logic                  edly_hit;

  // Saturating increments and "count reaches limit" compares on a common width
  always_comb begin
    idly_inc = (&idly_cnt) ? idly_cnt : idly_cnt + IDLY_WIDTH'(1);
    pls_inc  = (&pls_cnt)  ? pls_cnt  : pls_cnt  + PLS_WIDTH'(1);
    edly_inc = (&edly_cnt) ? edly_cnt : edly_cnt + EDLY_WIDTH'(1);
    tmo_on   = (tmo_q != '0);
    tmo_one  = tmo_on && (CMP_W'(tmo_q) == CMP_W'(1));
    idly_hit = tmo_on && (CMP_W'(idly_inc) == CMP_W'(tmo_q));
    pls_hit  = tmo_on && (CMP_W'(pls_inc)  == CMP_W'(tmo_q));
    edly_hit = tmo_on && (CMP_W'(edly_inc) == CMP_W'(tmo_q));
  end

  // The ALIGN state absorbs the two-flop synchronizer latency so that the
  // first processed sample is the raw IN value taken one edge after arming.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      align      <= 1'b0;
      in_s1      <= 1'b0;
      in_s2      <= 1'b0;
      tmo_q      <= '0;
      idly_cnt   <= '0;
      pls_cnt    <= '0;
      edly_cnt   <= '0;
      err_q      <= '0;
      bus.BUSY   <= 1'b0;
      bus.DONE   <= 1'b0;
      bus.idly_m <= '0;
      bus.pls_m  <= '0;
      bus.edly_m <= '0;
      bus.err    <= '0;
    end else begin
      in_s1    <= bus.IN;
      in_s2    <= in_s1;
      bus.DONE <= 1'b0;

      case (state)
        S_IDLE: begin
          // A request coinciding with the DONE strobe is dropped
          if (bus.START && !bus.DONE) begin
            tmo_q    <= bus.tmo;
            idly_cnt <= '0;
            pls_cnt  <= '0;
            edly_cnt <= '0;
            err_q    <= '0;
            align    <= 1'b0;
            bus.BUSY <= 1'b1;
            state    <= S_ALIGN;
          end
        end

        S_ALIGN: begin
          align <= 1'b1;
          if (align) begin
            state <= S_WAIT_HI;
          end
        end

        S_WAIT_HI: begin
          if (in_s2) begin
            pls_cnt <= PLS_WIDTH'(1);
            if (tmo_one) begin
              err_q[1] <= 1'b1;
              state    <= S_FIN;
            end else begin
              state <= S_HIGH;
            end
          end else begin
            idly_cnt <= idly_inc;
            if (idly_hit) begin
              err_q[0] <= 1'b1;
              state    <= S_FIN;
            end
          end
        end

        S_HIGH: begin
          if (in_s2) begin
            pls_cnt <= pls_inc;
            if (pls_hit) begin
              err_q[1] <= 1'b1;
              state    <= S_FIN;
            end
          end else begin
            edly_cnt <= EDLY_WIDTH'(1);
            if (tmo_one) begin
              err_q[2] <= 1'b1;
              state    <= S_FIN;
            end else begin
              state <= S_LOW_POST;
            end
          end
        end

        S_LOW_POST: begin
          // The rising edge that ends the post-pulse gap is not counted
          if (in_s2) begin
            state <= S_FIN;
          end else begin
            edly_cnt <= edly_inc;
            if (edly_hit) begin
              err_q[2] <= 1'b1;
              state    <= S_FIN;
            end
          end
        end

        S_FIN: begin
          bus.idly_m <= idly_cnt;
          bus.pls_m  <= pls_cnt;
          bus.edly_m <= edly_cnt;
          bus.err    <= err_q;
          bus.DONE   <= 1'b1;
          bus.BUSY   <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          bus.BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_pls_meas.sv
// Directed bench for nmr_bstrm_pls_meas: phase lengths, timeouts, re-arm rules and reset.
module tb_nmr_bstrm_pls_meas;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  nmr_bstrm_pls_meas_if #(
    .IDLY_WIDTH(32), .PLS_WIDTH(32), .EDLY_WIDTH(32), .TMO_WIDTH(32)
  ) bus ();

  nmr_bstrm_pls_meas #(
    .IDLY_WIDTH(32), .PLS_WIDTH(32), .EDLY_WIDTH(32), .TMO_WIDTH(32)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream value at sample k: low a, high b, low c, then high forever
  function automatic logic pat(input int k, input int a, input int b, input int c);
    if (k <= a)             return 1'b0;
    else if (k <= a + b)    return 1'b1;
    else if (k <= a + b + c) return 1'b0;
    else                    return 1'b1;
  endfunction

  task automatic meas(input string tag, input int a, input int b, input int c,
                      input logic [31:0] tmo_v, input int busy_start_k, input bit start_at_done,
                      input int exp_done, input logic [31:0] ei, input logic [31:0] ep,
                      input logic [31:0] ee, input logic [2:0] eerr);
    int done_k;
    done_k    = -1;
    bus.tmo   = tmo_v;
    bus.IN    = 1'b0;
    bus.START = 1'b1;
    step();                                  // edge 0
    bus.START = 1'b0;
    bus.tmo   = 32'd3;                       // must not affect the armed run
    chk({tag, "_busy_rise"}, 64'(bus.BUSY), 64'(1));
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      bus.IN    = pat(k, a, b, c);
      bus.START = (k == busy_start_k);
      step();
      if (bus.DONE) done_k = k;
    end
    bus.START = 1'b0;
    chk({tag, "_done_edge"}, 64'(done_k), 64'(exp_done));
    chk({tag, "_idly"}, 64'(bus.idly_m), 64'(ei));
    chk({tag, "_pls"},  64'(bus.pls_m),  64'(ep));
    chk({tag, "_edly"}, 64'(bus.edly_m), 64'(ee));
    chk({tag, "_err"},  64'(bus.err),    64'(eerr));
    chk({tag, "_busy_fall"}, 64'(bus.BUSY), 64'(0));
    bus.START = start_at_done;
    step();
    bus.START = 1'b0;
    chk({tag, "_done_one_cycle"}, 64'(bus.DONE), 64'(0));
    chk({tag, "_no_rearm_on_done"}, 64'(bus.BUSY), 64'(0));
    chk({tag, "_hold_pls"}, 64'(bus.pls_m), 64'(ep));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RST       = 1'b1;
    bus.START = 1'b0;
    bus.IN    = 1'b0;
    bus.tmo   = '0;
    step();
    step();
    chk("rst_busy", 64'(bus.BUSY),   64'(0));
    chk("rst_done", 64'(bus.DONE),   64'(0));
    chk("rst_idly", 64'(bus.idly_m), 64'(0));
    chk("rst_pls",  64'(bus.pls_m),  64'(0));
    chk("rst_edly", 64'(bus.edly_m), 64'(0));
    chk("rst_err",  64'(bus.err),    64'(0));
    RST = 1'b0;
    step();

    // Normal pulse: rising edge at sample 18, DONE at edge 21; START held in DONE cycle
    meas("normal", 5, 7, 5, 32'd0, -1, 1'b1, 21, 32'd5, 32'd7, 32'd5, 3'b000);
    // Immediate re-arm after DONE; IN high at sample 1: terminates at sample 8
    meas("imm_high", 0, 4, 3, 32'd0, -1, 1'b0, 11, 32'd0, 32'd4, 32'd3, 3'b000);
    // Idle-low timeout: count reaches 20 at sample 20
    meas("tmo_idly", 1000, 0, 0, 32'd20, -1, 1'b0, 23, 32'd20, 32'd0, 32'd0, 3'b001);
    // Pulse timeout: high from sample 3, pls reaches 20 at sample 22
    meas("tmo_pls", 2, 1000, 0, 32'd20, -1, 1'b0, 25, 32'd2, 32'd20, 32'd0, 3'b010);
    // Post-pulse timeout: low from sample 6, edly reaches 20 at sample 25
    meas("tmo_edly", 2, 3, 1000, 32'd20, -1, 1'b0, 28, 32'd2, 32'd3, 32'd20, 3'b100);
    // START pulsed mid-measurement is ignored; terminates at sample 10
    meas("busy_start", 3, 2, 4, 32'd0, 6, 1'b0, 13, 32'd3, 32'd2, 32'd4, 3'b000);

    // Reset asserted while measuring the pulse
    bus.tmo   = '0;
    bus.IN    = 1'b0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.IN = pat(k, 2, 10, 2);
      step();
    end
    chk("pre_rst_busy", 64'(bus.BUSY), 64'(1));
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_busy", 64'(bus.BUSY),   64'(0));
    chk("async_rst_idly", 64'(bus.idly_m), 64'(0));
    chk("async_rst_pls",  64'(bus.pls_m),  64'(0));
    chk("async_rst_edly", 64'(bus.edly_m), 64'(0));
    chk("async_rst_err",  64'(bus.err),    64'(0));
    step();
    RST = 1'b0;
    step();
    step();
    chk("post_rst_busy", 64'(bus.BUSY), 64'(0));
    chk("post_rst_done", 64'(bus.DONE), 64'(0));

    // Clean measurement after reset: edge at sample 4, DONE at edge 7
    meas("after_rst", 1, 1, 1, 32'd0, -1, 1'b0, 7, 32'd1, 32'd1, 32'd1, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
